bsg_lru_pseudo_tree_tracker: RTL and testbench
==============================================

# bsg_lru_pseudo_tree_tracker

Multi-set pseudo-LRU replacement tracker for set-associative caches. Holds one (ways_p-1)-bit binary tree of LRU bits per set, updates it on hits (touch) and allocations, and returns the allocation victim. Invalid ways take priority over the LRU way. It sits beside the tag array in the cache pipeline and replaces the combinational tree encoder plus its externally kept LRU flops.

## Interface
- ways_p, default 8: associativity; power of 2, at least 2.
- sets_p, default 16: number of independently tracked sets; at least 1.
- Derived widths: lg_ways = log2(ways_p). lg_sets = max(1, ceil(log2(sets_p))).

- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear of all tree bits in all sets.
- touch_v_i  in  1  hit update request.
- touch_set_i  in  lg_sets  set index of the hit.
- touch_way_i  in  lg_ways  way index of the hit.
- alloc_v_i  in  1  victim request; always accepted.
- alloc_set_i  in  lg_sets  set index for the allocation.
- alloc_valid_mask_i  in  ways_p  bit w set means way w currently holds valid data.
- alloc_v_o  out  1  victim result valid; single-cycle pulse.
- alloc_set_o  out  lg_sets  set index echoed with the result.
- alloc_way_o  out  lg_ways  chosen victim way.

## Operation
- **Tree layout:** heap layout. Node 0 is the root. Children of node n are 2n+1 (lower half of ways) and 2n+2 (upper half). Node bit value gives the LRU direction: 0 = lower, 1 = upper.
- **LRU way:** walk from the root. At each level the node bit becomes the next way-index bit, MSB first.
- **Touch of way w:** every node on w's path is set to the complement of w's bit at that level, so the path points away from w. Nodes off the path are unchanged.
- **Victim selection:**
  - If alloc_valid_mask_i is not all-ones, the victim is the lowest-index way with its mask bit at 0.
  - Otherwise the victim is the LRU way.
  - Either way, the chosen victim is then touched in that set.
- **Same cycle, different sets:** touch and alloc both apply independently.
- **Same cycle, same set:** the touch is applied first. The victim is computed from the post-touch tree, and the victim's touch is applied last. The final stored bits are the touch update followed by the victim update on the same node values.
- **Out-of-range set:** an index of sets_p or above is a usage error. Behaviour is unspecified; an assertion flags it in simulation.
- **clear_i:** has priority over touch and alloc in the same cycle. All bits go to 0. An alloc in that cycle still produces its output, computed from the pre-clear state.

## Timing
- **Reset (reset_n_i low):** all tree bits 0 immediately. alloc_v_o = 0, alloc_set_o = 0, alloc_way_o = 0.
- **Reset mid-operation:** a pending output pulse is dropped.
- **Touch latency:** a touch sampled at edge N is visible to an alloc sampled at edge N+1.
- **Alloc latency:** an alloc sampled at edge N drives alloc_v_o = 1 with a registered set and way during cycle N+1 only.
- **Back-to-back:** one alloc per cycle sustained. There is no output backpressure; the consumer must take the result in the cycle it is presented.
- **Alloc to same set:** consecutive allocs to one set see each other's updates. No bubbles are needed.
- **Critical path:** set-index mux, then tree walk, then priority encode, then write-back. This is a single cycle; no internal pipeline beyond the output register.

## Test plan
- **Reset and LRU sequence:** ways_p=8, sets_p=16, mask all-ones. Release reset, then issue 8 back-to-back allocs to set 3. alloc_way_o must be 0,4,2,6,1,5,3,7, each one cycle after its request. After a ninth alloc, the returned way must be 0 again.
- **Invalid-way priority:** set 5 after reset. Alloc with mask 8'b1111_0111 → way 3. Alloc with mask 8'b1111_1111 → way 4, because way 3 was touched.
- **Touch steers LRU:** after reset, touch set 2 way 0, then alloc set 2 with full mask on the next cycle → way 4. Touch way 4, then alloc → way 2.
- **Same-cycle collision:** after reset, in one cycle touch set 7 way 0 and alloc set 7 with full mask → way 4. Next alloc to set 7 → way 2. Repeat using different sets 7 and 8 → alloc returns way 0, and set 7 still yields 4 on its next alloc.
- **Clear and async reset:**
  - Advance set 1 through 3 allocs, then pulse clear_i → next alloc → way 0.
  - Assert reset_n_i low mid-cycle with an alloc in flight → alloc_v_o falls to 0 without a clock edge, and no pulse appears after release.
- **Degenerate params:** ways_p=2, sets_p=1, full mask. Allocs alternate 0,1,0,1, and alloc_set_o stays 0.

Source files
------------

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Multi-set pseudo-LRU tracker: one (ways_p-1)-bit heap-ordered tree per set.
// Touches update the tree on hits; allocs pick a victim (invalid ways first) and touch it.
module bsg_lru_pseudo_tree_tracker #(
    parameter int ways_p = 8,
    parameter int sets_p = 16,
    localparam int lg_ways = $clog2(ways_p),
    localparam int lg_sets = (sets_p > 1) ? $clog2(sets_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               touch_v_i,
    input  logic [lg_sets-1:0] touch_set_i,
    input  logic [lg_ways-1:0] touch_way_i,
    input  logic               alloc_v_i,
    input  logic [lg_sets-1:0] alloc_set_i,
    input  logic [ways_p-1:0]  alloc_valid_mask_i,
    output logic               alloc_v_o,
    output logic [lg_sets-1:0] alloc_set_o,
    output logic [lg_ways-1:0] alloc_way_o
);

    logic [ways_p-2:0] tree_q [sets_p];
    logic [ways_p-2:0] tree_d [sets_p];

    logic               alloc_v_q, alloc_v_d;
    logic [lg_sets-1:0] alloc_set_q, alloc_set_d;
    logic [lg_ways-1:0] alloc_way_q, alloc_way_d;

    // Point every node on the way's path away from it, walking MSB first.
    function automatic logic [ways_p-2:0] touch_path(input logic [ways_p-2:0] tree,
                                                     input logic [lg_ways-1:0] way);
        logic [ways_p-2:0] t;
        logic [lg_ways-1:0] n;
        logic [lg_ways-1:0] w;
        logic               b;
        t = tree;
        n = '0;
        w = way;
        for (int l = 0; l < lg_ways; l++) begin
            b    = w[lg_ways-1];
            t[n] = ~b;
            n    = (n << 1) + lg_ways'(1) + lg_ways'(b);
            w    = w << 1;
        end
        return t;
    endfunction

    function automatic logic [lg_ways-1:0] lru_way(input logic [ways_p-2:0] tree);
        logic [lg_ways-1:0] n;
        logic [lg_ways-1:0] way;
        logic               b;
        n   = '0;
        way = '0;
        for (int l = 0; l < lg_ways; l++) begin
            b   = tree[n];
            way = (way << 1) | lg_ways'(b);
            n   = (n << 1) + lg_ways'(1) + lg_ways'(b);
        end
        return way;
    endfunction

    function automatic logic [lg_ways-1:0] pick_victim(input logic [ways_p-2:0] tree,
                                                       input logic [ways_p-1:0] mask);
        logic [lg_ways-1:0] way;
        logic [ways_p-1:0]  m;
        logic               found;
        way   = lru_way(tree);
        m     = mask;
        found = 1'b0;
        for (int w = 0; w < ways_p; w++) begin
            if (!found && !m[0]) begin
                way   = lg_ways'(w);
                found = 1'b1;
            end
            m = m >> 1;
        end
        return way;
    endfunction

    logic [ways_p-2:0]  touch_tree, touched_tree;
    logic [ways_p-2:0]  alloc_tree, alloc_base, alloc_final;
    logic [lg_ways-1:0] victim;
    logic               same_set;

    always_comb begin
        touch_tree = '0;
        alloc_tree = '0;
        for (int s = 0; s < sets_p; s++) begin
            if (touch_set_i == lg_sets'(s)) touch_tree = tree_q[s];
            if (alloc_set_i == lg_sets'(s)) alloc_tree = tree_q[s];
        end

        touched_tree = touch_path(touch_tree, touch_way_i);
        same_set     = touch_v_i && (touch_set_i == alloc_set_i);
        // A same-set touch lands before the victim is chosen.
        alloc_base   = same_set ? touched_tree : alloc_tree;
        victim       = pick_victim(alloc_base, alloc_valid_mask_i);
        alloc_final  = touch_path(alloc_base, victim);

        for (int s = 0; s < sets_p; s++) begin
            tree_d[s] = tree_q[s];
            if (touch_v_i && touch_set_i == lg_sets'(s)) tree_d[s] = touched_tree;
            if (alloc_v_i && alloc_set_i == lg_sets'(s)) tree_d[s] = alloc_final;
            if (clear_i) tree_d[s] = '0;
        end

        alloc_v_d   = alloc_v_i;
        alloc_set_d = alloc_v_i ? alloc_set_i : alloc_set_q;
        alloc_way_d = alloc_v_i ? victim : alloc_way_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < sets_p; s++) tree_q[s] <= '0;
            alloc_v_q   <= 1'b0;
            alloc_set_q <= '0;
            alloc_way_q <= '0;
        end else begin
            tree_q      <= tree_d;
            alloc_v_q   <= alloc_v_d;
            alloc_set_q <= alloc_set_d;
            alloc_way_q <= alloc_way_d;
        end
    end

    assign alloc_v_o   = alloc_v_q;
    assign alloc_set_o = alloc_set_q;
    assign alloc_way_o = alloc_way_q;

`ifndef SYNTHESIS
    a_touch_set_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        touch_v_i |-> (int'(touch_set_i) < sets_p));
    a_alloc_set_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        alloc_v_i |-> (int'(alloc_set_i) < sets_p));
`endif

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// Scoreboard bench for bsg_lru_pseudo_tree_tracker: an 8-way/16-set instance and a
// 2-way/1-set instance, each checked against an index-arithmetic tree model.
module tb_bsg_lru_pseudo_tree_tracker;

    localparam int WAYS = 8;
    localparam int SETS = 16;
    localparam int LG   = 3;
    localparam int LGS  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            touch_v = 1'b0;
    logic [LGS-1:0]  touch_set = '0;
    logic [LG-1:0]   touch_way = '0;
    logic            alloc_v = 1'b0;
    logic [LGS-1:0]  alloc_set = '0;
    logic [WAYS-1:0] alloc_mask = '1;
    logic            alloc_v_o;
    logic [LGS-1:0]  alloc_set_o;
    logic [LG-1:0]   alloc_way_o;

    logic            clear2 = 1'b0;
    logic            touch_v2 = 1'b0;
    logic [0:0]      touch_set2 = '0;
    logic [0:0]      touch_way2 = '0;
    logic            alloc_v2 = 1'b0;
    logic [0:0]      alloc_set2 = '0;
    logic [1:0]      alloc_mask2 = '1;
    logic            alloc_v_o2;
    logic [0:0]      alloc_set_o2;
    logic [0:0]      alloc_way_o2;

    bsg_lru_pseudo_tree_tracker #(.ways_p(WAYS), .sets_p(SETS)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear),
        .touch_v_i(touch_v), .touch_set_i(touch_set), .touch_way_i(touch_way),
        .alloc_v_i(alloc_v), .alloc_set_i(alloc_set), .alloc_valid_mask_i(alloc_mask),
        .alloc_v_o(alloc_v_o), .alloc_set_o(alloc_set_o), .alloc_way_o(alloc_way_o)
    );

    bsg_lru_pseudo_tree_tracker #(.ways_p(2), .sets_p(1)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear2),
        .touch_v_i(touch_v2), .touch_set_i(touch_set2), .touch_way_i(touch_way2),
        .alloc_v_i(alloc_v2), .alloc_set_i(alloc_set2), .alloc_valid_mask_i(alloc_mask2),
        .alloc_v_o(alloc_v_o2), .alloc_set_o(alloc_set_o2), .alloc_way_o(alloc_way_o2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct { int set; int way; } exp_t;
    exp_t q[$];
    int   q2[$];

    // Reference trees: level l node for way w sits at 2^l - 1 + (top l bits of w).
    bit mt [SETS][WAYS-1];
    bit m2;

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++) mt[s][n] = 1'b0;
    endfunction

    function automatic void m_touch(int s, int w);
        for (int l = 0; l < LG; l++) begin
            int node;
            node = (1 << l) - 1 + (w >> (LG - l));
            mt[s][node] = ((w >> (LG - 1 - l)) & 1) == 0;
        end
    endfunction

    function automatic int m_victim(int s, logic [WAYS-1:0] mask);
        int w;
        if (mask != '1) begin
            for (int i = 0; i < WAYS; i++) if (!mask[i]) return i;
        end
        w = 0;
        for (int l = 0; l < LG; l++) w = (w << 1) | int'(mt[s][(1 << l) - 1 + w]);
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (alloc_v_o) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                chk("alloc_set", int'(alloc_set_o), e.set);
                chk("alloc_way", int'(alloc_way_o), e.way);
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (alloc_v_o2) begin
            if (q2.size() == 0) begin
                chk("unexpected_pulse2", 1, 0);
            end else begin
                w = q2.pop_front();
                chk("alloc_set2", int'(alloc_set_o2), 0);
                chk("alloc_way2", int'(alloc_way_o2), w);
            end
        end
    end

    // One cycle of stimulus; exp >= 0 overrides the model's victim with a known constant.
    task automatic step(input bit tv, input int ts, input int tw, input bit av, input int as,
                        input logic [WAYS-1:0] mask, input bit clr, input int exp);
        exp_t e;
        touch_v    = tv;
        touch_set  = LGS'(ts);
        touch_way  = LG'(tw);
        alloc_v    = av;
        alloc_set  = LGS'(as);
        alloc_mask = mask;
        clear      = clr;
        if (tv) m_touch(ts, tw);
        if (av) begin
            e.set = as;
            e.way = m_victim(as, mask);
            m_touch(as, e.way);
            if (exp >= 0) e.way = exp;
            q.push_back(e);
        end
        if (clr) m_clear();
        @(posedge clk);
        #1;
        touch_v = 1'b0;
        alloc_v = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic step2(input bit tv, input int tw, input bit av, input logic [1:0] mask,
                         input int exp);
        int v;
        touch_v2    = tv;
        touch_way2  = 1'(tw);
        alloc_v2    = av;
        alloc_mask2 = mask;
        if (tv) m2 = (tw == 0);
        if (av) begin
            if (mask != 2'b11) v = mask[0] ? 1 : 0;
            else v = int'(m2);
            m2 = (v == 0);
            q2.push_back((exp >= 0) ? exp : v);
        end
        @(posedge clk);
        #1;
        touch_v2 = 1'b0;
        alloc_v2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(2);
        rst_n = 1'b0;
        q.delete();
        q2.delete();
        m_clear();
        m2 = 1'b0;
        idle(2);
        #3 rst_n = 1'b1;
        idle(1);
    endtask

    localparam logic [WAYS-1:0] FULL = '1;

    initial begin
        int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        m_clear();
        m2 = 1'b0;
        #2;
        chk("reset_alloc_v", int'(alloc_v_o), 0);
        chk("reset_alloc_set", int'(alloc_set_o), 0);
        chk("reset_alloc_way", int'(alloc_way_o), 0);
        idle(2);
        #3 rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3, FULL, 0, seq[i]);
        step(0, 0, 0, 1, 3, FULL, 0, 0);

        step(0, 0, 0, 1, 5, 8'b1111_0111, 0, 3);
        step(0, 0, 0, 1, 5, FULL, 0, 4);

        step(1, 2, 0, 0, 0, FULL, 0, -1);
        step(0, 0, 0, 1, 2, FULL, 0, 4);
        step(1, 2, 4, 0, 0, FULL, 0, -1);
        step(0, 0, 0, 1, 2, FULL, 0, 2);

        step(1, 7, 0, 1, 7, FULL, 0, 4);
        step(0, 0, 0, 1, 7, FULL, 0, 2);
        do_reset();
        step(1, 7, 0, 1, 8, FULL, 0, 0);
        step(0, 0, 0, 1, 7, FULL, 0, 4);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, FULL, 0, -1);
        step(0, 0, 0, 0, 0, FULL, 1, -1);
        step(0, 0, 0, 1, 1, FULL, 0, 0);
        // Alloc in the clear cycle still reports from the pre-clear tree.
        step(0, 0, 0, 1, 1, FULL, 1, 4);
        step(0, 0, 0, 1, 1, FULL, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int ts, as;
            logic [WAYS-1:0] mask;
            ts   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, SETS - 1);
            as   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, SETS - 1);
            mask = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : FULL;
            step($urandom_range(0, 1) == 1, ts, $urandom_range(0, WAYS - 1),
                 $urandom_range(0, 9) < 6, as, mask, $urandom_range(0, 49) == 0, -1);
        end
        idle(2);

        step(0, 0, 0, 1, 6, FULL, 0, -1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_drop", int'(alloc_v_o), 0);
        q.delete();
        m_clear();
        m2 = 1'b0;
        idle(2);
        #3 rst_n = 1'b1;
        idle(4);
        step(0, 0, 0, 1, 6, FULL, 0, 0);

        step2(0, 0, 1, 2'b11, 0);
        step2(0, 0, 1, 2'b11, 1);
        step2(0, 0, 1, 2'b11, 0);
        step2(0, 0, 1, 2'b11, 1);
        for (int i = 0; i < 60; i++)
            step2($urandom_range(0, 1) == 1, $urandom_range(0, 1), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11, -1);

        idle(3);
        chk("queue_drained", q.size(), 0);
        chk("queue2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
